ctrl_unit_seq: RTL and testbench
================================

// Module: ctrl_unit_seq
// PURPOSE
//  Registered, handshaked successor to the combinational opcode decoder; sits between fetch and execute.
//  Accepts one opcode per handshake and emits a registered control word one cycle later.
//  Stalls fetch for multi-cycle MUL/DIV and latches HALT. Flags undefined opcodes.
//  Every output is defined for every opcode; no x and no held-over values.
// PARAMETERS
//  OPCODE_W       6  opcode width
//  ALUOP_W        6  ALU-op width
//  MULDIV_CYCLES  4  cycles from accept to out_valid for MUL/MULI/DIV/DIVI (>=1)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  in_valid    in   1        opcode valid from fetch
//  in_ready    out  1        decoder can accept
//  opcode      in   OPCODE_W instruction opcode
//  flush       in   1        kill pending/held word (branch/jump taken)
//  out_valid   out  1        control word valid
//  out_ready   in   1        execute consumes word
//  alu_op      out  ALUOP_W  ALU operation
//  reg_dst, branch_and, jump_reg, jump, jal, mem_read, mem_to_reg,
//  mem_write, immediate, reg_write, print
//              out  1 each   control flags
//  illegal     out  1        word came from an undefined opcode (all flags 0)
//  halted      out  1        HALT accepted; sticky until reset
// BEHAVIOUR
//  Reset: all outputs 0. State S_RUN. Counter 0.
//  Opcode map (hex):
//   00 ADD,01 ADDI,02 SUB,03 SUBI,04 MUL,05 MULI,06 DIV,07 DIVI,08 AND,09 ANDI,0A OR,0B ORI,
//   0C XOR,0D XORI,0E NOT,0F SLL,10 SRL,11 J,12 JAL,13 JR,14 BEQ,15 BNE,16 BLT,17 BGT,
//   18 BLTZ,19 BGTZ,1A SLT,1B SLET,1C SGT,1D SGE,1E LI,1F LW,20 SW,21 PRINT,3F HALT.
//  ALU-op map (hex):
//   ADD/LI/LW/SW 00, SUB 01, MUL 02, DIV 03, AND 05, OR 06, XOR 07, NOT 08, SLT/BLT 09,
//   SLET 0A, SGT/BGT 0B, SGE 0C, BEQ 0D, BNE 0E, BLTZ 0F, BGTZ 11, SRL 13, SLL 14.
//   All other opcodes: 00.
//  Flags:
//   R-type arith/logic/shift/set: reg_write=1.
//   xxI and LI: additionally reg_dst=1, immediate=1.
//   NOT: reg_dst=1, reg_write=1.
//   Branches: branch_and=1. J: jump=1. JAL: jump=1, jal=1. JR: jump_reg=1.
//   LW: reg_dst, immediate, mem_read, mem_to_reg, reg_write=1.
//   SW: reg_dst, immediate, mem_write=1. PRINT: print=1.
//   branch (port), and any flag not listed for an opcode: 0.
//  Handshake: accept = in_valid & in_ready.
//   in_ready = (state==S_RUN) & (!out_valid | out_ready) & !flush.
//  Output register: a word is held stable while out_valid & !out_ready.
//   out_valid drops after consume unless a new accept occurs in the same cycle (back-to-back, 1/cycle).
//  Latency: 1 cycle for non-MUL/DIV opcodes.
//  MUL/MULI/DIV/DIVI: on accept, go to S_BUSY and load counter = MULDIV_CYCLES-1.
//   Decrement each cycle. Word is registered internally.
//   At count 0, out_valid rises (total MULDIV_CYCLES cycles after accept); return to S_RUN.
//   MULDIV_CYCLES=1 behaves as 1-cycle latency. in_ready=0 throughout S_BUSY.
//  HALT: on accept, go to S_HALT. halted=1 next cycle. out_valid=0. in_ready=0 forever.
//   Leaves S_HALT only via rst_n. No control word is emitted for HALT.
//  Undefined opcode: accepted; emits a word with all flags 0, alu_op=0, illegal=1. No state change.
//  flush: out_valid clears next cycle and any S_BUSY word is discarded (-> S_RUN, counter 0).
//   flush wins over a same-cycle accept. flush has no effect in S_HALT.
//  rst_n low mid-MUL/DIV or mid-hold: immediate return to reset values (asynchronous).
// STRUCTURE
//  Package ctrl_pkg: opcode localparams, ALU-op localparams, packed ctrl_word_t
//   (alu_op + 11 flags + illegal), state enum {S_RUN,S_BUSY,S_HALT}.
//  One sub-module: ctrl_decode_lut (pure combinational opcode->ctrl_word_t).
//  This top holds the FSM, counter ($clog2(MULDIV_CYCLES+1) bits) and output register.
// TESTING
//  Reset: rst_n=0 -> all outputs 0. After release: in_ready=1.
//  ADDI(01) accepted -> next cycle out_valid=1, alu_op=00, reg_dst=immediate=reg_write=1, others 0.
//  Back-pressure: SW(20) then out_ready=0 for 3 cycles -> word stable, in_ready=0.
//   out_ready=1 with LW(1F) pending -> LW word next cycle.
//  DIV(06), MULDIV_CYCLES=4 -> in_ready=0 for 4 cycles, out_valid at accept+4, alu_op=03.
//   Repeat with flush at accept+2 -> no word emitted, in_ready=1 at accept+3.
//  HALT(3F) -> halted=1 next cycle, in_ready stays 0 for 20 cycles with in_valid=1.
//   Pulse rst_n -> recovers.
//  Opcode 2A -> out_valid=1, illegal=1, all flags 0. Then PRINT(21) -> print=1, illegal=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode/ALU-op encodings, control word layout and FSM states for the
// registered control unit.
package ctrl_pkg;

  localparam int OPC_W = 6;
  localparam int ALU_W = 6;

  localparam logic [OPC_W-1:0] OP_ADD   = 6'h00;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h01;
  localparam logic [OPC_W-1:0] OP_SUB   = 6'h02;
  localparam logic [OPC_W-1:0] OP_SUBI  = 6'h03;
  localparam logic [OPC_W-1:0] OP_MUL   = 6'h04;
  localparam logic [OPC_W-1:0] OP_MULI  = 6'h05;
  localparam logic [OPC_W-1:0] OP_DIV   = 6'h06;
  localparam logic [OPC_W-1:0] OP_DIVI  = 6'h07;
  localparam logic [OPC_W-1:0] OP_AND   = 6'h08;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h09;
  localparam logic [OPC_W-1:0] OP_OR    = 6'h0A;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0B;
  localparam logic [OPC_W-1:0] OP_XOR   = 6'h0C;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'h0D;
  localparam logic [OPC_W-1:0] OP_NOT   = 6'h0E;
  localparam logic [OPC_W-1:0] OP_SLL   = 6'h0F;
  localparam logic [OPC_W-1:0] OP_SRL   = 6'h10;
  localparam logic [OPC_W-1:0] OP_J     = 6'h11;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h12;
  localparam logic [OPC_W-1:0] OP_JR    = 6'h13;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h14;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h15;
  localparam logic [OPC_W-1:0] OP_BLT   = 6'h16;
  localparam logic [OPC_W-1:0] OP_BGT   = 6'h17;
  localparam logic [OPC_W-1:0] OP_BLTZ  = 6'h18;
  localparam logic [OPC_W-1:0] OP_BGTZ  = 6'h19;
  localparam logic [OPC_W-1:0] OP_SLT   = 6'h1A;
  localparam logic [OPC_W-1:0] OP_SLET  = 6'h1B;
  localparam logic [OPC_W-1:0] OP_SGT   = 6'h1C;
  localparam logic [OPC_W-1:0] OP_SGE   = 6'h1D;
  localparam logic [OPC_W-1:0] OP_LI    = 6'h1E;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h1F;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h20;
  localparam logic [OPC_W-1:0] OP_PRINT = 6'h21;
  localparam logic [OPC_W-1:0] OP_HALT  = 6'h3F;

  localparam logic [ALU_W-1:0] ALU_ADD  = 6'h00;
  localparam logic [ALU_W-1:0] ALU_SUB  = 6'h01;
  localparam logic [ALU_W-1:0] ALU_MUL  = 6'h02;
  localparam logic [ALU_W-1:0] ALU_DIV  = 6'h03;
  localparam logic [ALU_W-1:0] ALU_AND  = 6'h05;
  localparam logic [ALU_W-1:0] ALU_OR   = 6'h06;
  localparam logic [ALU_W-1:0] ALU_XOR  = 6'h07;
  localparam logic [ALU_W-1:0] ALU_NOT  = 6'h08;
  localparam logic [ALU_W-1:0] ALU_SLT  = 6'h09;
  localparam logic [ALU_W-1:0] ALU_SLET = 6'h0A;
  localparam logic [ALU_W-1:0] ALU_SGT  = 6'h0B;
  localparam logic [ALU_W-1:0] ALU_SGE  = 6'h0C;
  localparam logic [ALU_W-1:0] ALU_BEQ  = 6'h0D;
  localparam logic [ALU_W-1:0] ALU_BNE  = 6'h0E;
  localparam logic [ALU_W-1:0] ALU_BLTZ = 6'h0F;
  localparam logic [ALU_W-1:0] ALU_BGTZ = 6'h11;
  localparam logic [ALU_W-1:0] ALU_SRL  = 6'h13;
  localparam logic [ALU_W-1:0] ALU_SLL  = 6'h14;

  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             reg_dst;
    logic             branch_and;
    logic             jump_reg;
    logic             jump;
    logic             jal;
    logic             mem_read;
    logic             mem_to_reg;
    logic             mem_write;
    logic             immediate;
    logic             reg_write;
    logic             print;
    logic             illegal;
  } ctrl_word_t;

  typedef enum logic [1:0] {S_RUN, S_BUSY, S_HALT} state_e;

  function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULI) || (op == OP_DIV) || (op == OP_DIVI);
  endfunction

endpackage

// File: rtl/ctrl_decode_lut.sv
// Pure combinational opcode -> control word lookup; undefined opcodes yield
// an all-zero word with only the illegal bit set.
module ctrl_decode_lut
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_word_t       word
);

  always_comb begin
    word = '0;
    unique case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
      OP_SLT, OP_SLET, OP_SGT, OP_SGE:
        word.reg_write = 1'b1;
      OP_ADDI, OP_SUBI, OP_MULI, OP_DIVI, OP_ANDI, OP_ORI, OP_XORI, OP_LI: begin
        word.reg_dst   = 1'b1;
        word.immediate = 1'b1;
        word.reg_write = 1'b1;
      end
      OP_NOT: begin
        word.reg_dst   = 1'b1;
        word.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGT, OP_BLTZ, OP_BGTZ:
        word.branch_and = 1'b1;
      OP_J:   word.jump = 1'b1;
      OP_JAL: begin
        word.jump = 1'b1;
        word.jal  = 1'b1;
      end
      OP_JR:  word.jump_reg = 1'b1;
      OP_LW: begin
        word.reg_dst    = 1'b1;
        word.immediate  = 1'b1;
        word.mem_read   = 1'b1;
        word.mem_to_reg = 1'b1;
        word.reg_write  = 1'b1;
      end
      OP_SW: begin
        word.reg_dst   = 1'b1;
        word.immediate = 1'b1;
        word.mem_write = 1'b1;
      end
      OP_PRINT: word.print = 1'b1;
      OP_HALT:  word.illegal = 1'b0;
      default:  word.illegal = 1'b1;
    endcase

    // Immediate forms other than the ones named keep ALU op 00.
    unique case (opcode)
      OP_SUB:            word.alu_op = ALU_SUB;
      OP_MUL:            word.alu_op = ALU_MUL;
      OP_DIV:            word.alu_op = ALU_DIV;
      OP_AND:            word.alu_op = ALU_AND;
      OP_OR:             word.alu_op = ALU_OR;
      OP_XOR:            word.alu_op = ALU_XOR;
      OP_NOT:            word.alu_op = ALU_NOT;
      OP_SLT, OP_BLT:    word.alu_op = ALU_SLT;
      OP_SLET:           word.alu_op = ALU_SLET;
      OP_SGT, OP_BGT:    word.alu_op = ALU_SGT;
      OP_SGE:            word.alu_op = ALU_SGE;
      OP_BEQ:            word.alu_op = ALU_BEQ;
      OP_BNE:            word.alu_op = ALU_BNE;
      OP_BLTZ:           word.alu_op = ALU_BLTZ;
      OP_BGTZ:           word.alu_op = ALU_BGTZ;
      OP_SRL:            word.alu_op = ALU_SRL;
      OP_SLL:            word.alu_op = ALU_SLL;
      default:           word.alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_seq.sv
// Registered, handshaked control unit between fetch and execute: one opcode per
// accept, multi-cycle stall for MUL/DIV, sticky HALT, flush kills pending work.
module ctrl_unit_seq
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 6,
  parameter int ALUOP_W       = 6,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                reg_dst,
  output logic                branch_and,
  output logic                jump_reg,
  output logic                jump,
  output logic                jal,
  output logic                mem_read,
  output logic                mem_to_reg,
  output logic                mem_write,
  output logic                immediate,
  output logic                reg_write,
  output logic                print,
  output logic                illegal,
  output logic                halted
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  ctrl_word_t       word_q, word_d;
  ctrl_word_t       dec_word;
  ctrl_word_t       out_word;
  logic             accept;

  ctrl_decode_lut u_lut (
    .opcode (opcode),
    .word   (dec_word)
  );

  assign in_ready = rst_n & (state_q == S_RUN) & (!out_valid_q | out_ready) & !flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    word_d      = word_q;
    unique case (state_q)
      S_RUN: begin
        if (flush) begin
          out_valid_d = 1'b0;
        end else begin
          if (out_valid_q && out_ready) out_valid_d = 1'b0;
          if (accept) begin
            if (opcode == OP_HALT) begin
              state_d = S_HALT;
            end else begin
              // The word register is free here: any previous word was consumed this cycle.
              word_d = dec_word;
              if (MULDIV_CYCLES > 1 && is_muldiv(opcode)) begin
                state_d = S_BUSY;
                cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
              end else begin
                out_valid_d = 1'b1;
              end
            end
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d     = S_RUN;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d     = S_RUN;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HALT: out_valid_d = 1'b0;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Data register carries no reset; the output gate below hides it until valid.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign out_word   = out_valid_q ? word_q : '0;
  assign out_valid  = out_valid_q;
  assign alu_op     = ALUOP_W'(out_word.alu_op);
  assign reg_dst    = out_word.reg_dst;
  assign branch_and = out_word.branch_and;
  assign jump_reg   = out_word.jump_reg;
  assign jump       = out_word.jump;
  assign jal        = out_word.jal;
  assign mem_read   = out_word.mem_read;
  assign mem_to_reg = out_word.mem_to_reg;
  assign mem_write  = out_word.mem_write;
  assign immediate  = out_word.immediate;
  assign reg_write  = out_word.reg_write;
  assign print      = out_word.print;
  assign illegal    = out_word.illegal;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Randomized plus directed bench for ctrl_unit_seq against a transaction-level
// reference model (latency countdown, table decode).
module tb_ctrl_unit_seq;

  localparam int N_MD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, flush, out_valid, out_ready;
  logic [5:0] opcode, alu_op;
  logic       reg_dst, branch_and, jump_reg, jump, jal, mem_read, mem_to_reg;
  logic       mem_write, immediate, reg_write, print, illegal, halted;
  logic [17:0] dut_word;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic        m_halt;
  logic        m_ov;
  int          m_busy;
  logic [17:0] m_word;
  logic [17:0] m_pend;
  int          halt_cycles;

  always #5 clk = ~clk;

  ctrl_unit_seq #(.OPCODE_W(6), .ALUOP_W(6), .MULDIV_CYCLES(N_MD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .reg_dst(reg_dst), .branch_and(branch_and), .jump_reg(jump_reg),
    .jump(jump), .jal(jal), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .immediate(immediate), .reg_write(reg_write),
    .print(print), .illegal(illegal), .halted(halted)
  );

  assign dut_word = {alu_op, reg_dst, branch_and, jump_reg, jump, jal, mem_read,
                     mem_to_reg, mem_write, immediate, reg_write, print, illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: {alu_op, reg_dst, branch_and, jump_reg, jump, jal,
  // mem_read, mem_to_reg, mem_write, immediate, reg_write, print, illegal}
  function automatic logic [17:0] ref_decode(input logic [5:0] op);
    logic [5:0] a;
    logic rd, ba, jr, j, jl, mr, m2r, mw, imm, rw, pr, ill;
    {a, rd, ba, jr, j, jl, mr, m2r, mw, imm, rw, pr, ill} = '0;
    case (op)
      6'h02: a = 6'h01;  6'h04: a = 6'h02;  6'h06: a = 6'h03;  6'h08: a = 6'h05;
      6'h0A: a = 6'h06;  6'h0C: a = 6'h07;  6'h0E: a = 6'h08;  6'h1A: a = 6'h09;
      6'h16: a = 6'h09;  6'h1B: a = 6'h0A;  6'h1C: a = 6'h0B;  6'h17: a = 6'h0B;
      6'h1D: a = 6'h0C;  6'h14: a = 6'h0D;  6'h15: a = 6'h0E;  6'h18: a = 6'h0F;
      6'h19: a = 6'h11;  6'h10: a = 6'h13;  6'h0F: a = 6'h14;
      default: a = 6'h00;
    endcase
    if (op inside {6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A, 6'h0C, 6'h0F, 6'h10,
                   6'h1A, 6'h1B, 6'h1C, 6'h1D}) rw = 1'b1;
    if (op inside {6'h01, 6'h03, 6'h05, 6'h07, 6'h09, 6'h0B, 6'h0D, 6'h1E}) begin
      rd = 1'b1; imm = 1'b1; rw = 1'b1;
    end
    if (op == 6'h0E) begin rd = 1'b1; rw = 1'b1; end
    if (op >= 6'h14 && op <= 6'h19) ba = 1'b1;
    if (op == 6'h11) j = 1'b1;
    if (op == 6'h12) begin j = 1'b1; jl = 1'b1; end
    if (op == 6'h13) jr = 1'b1;
    if (op == 6'h1F) begin rd = 1'b1; imm = 1'b1; mr = 1'b1; m2r = 1'b1; rw = 1'b1; end
    if (op == 6'h20) begin rd = 1'b1; imm = 1'b1; mw = 1'b1; end
    if (op == 6'h21) pr = 1'b1;
    if (op > 6'h21 && op != 6'h3F) ill = 1'b1;
    return {a, rd, ba, jr, j, jl, mr, m2r, mw, imm, rw, pr, ill};
  endfunction

  function automatic logic ref_ready(input logic fl, input logic ordy);
    return !m_halt && (m_busy == 0) && (!m_ov || ordy) && !fl;
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input logic iv, input logic [5:0] op, input logic fl, input logic ordy);
    logic acc;
    acc = iv && ref_ready(fl, ordy);
    if (m_halt) begin
      // nothing leaves HALT except reset
    end else if (fl) begin
      m_ov = 1'b0;
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_ov = 1'b1;
        m_word = m_pend;
      end
    end else begin
      if (m_ov && ordy) m_ov = 1'b0;
      if (acc) begin
        if (op == 6'h3F) begin
          m_halt = 1'b1;
        end else if (op inside {6'h04, 6'h05, 6'h06, 6'h07} && N_MD > 1) begin
          m_busy = N_MD;
          m_pend = ref_decode(op);
        end else begin
          m_ov = 1'b1;
          m_word = ref_decode(op);
        end
      end
    end
  endtask

  task automatic cyc(input logic iv, input logic [5:0] op, input logic fl, input logic ordy);
    @(negedge clk);
    in_valid = iv; opcode = op; flush = fl; out_ready = ordy;
    #1;
    check_eq("in_ready", in_ready, ref_ready(fl, ordy));
    check_eq("out_valid", out_valid, m_ov);
    check_eq("halted", halted, m_halt);
    if (m_ov) check_eq("word", dut_word, m_word);
    @(posedge clk);
    model_step(iv, op, fl, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; opcode = 6'h00;
    #1;
    check_eq("reset_outputs", {in_ready, out_valid, halted, dut_word}, 32'h0);
    m_halt = 1'b0; m_ov = 1'b0; m_busy = 0; m_word = '0; m_pend = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] op;
    int r;
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; opcode = 6'h00;
    m_halt = 1'b0; m_ov = 1'b0; m_busy = 0; m_word = '0; m_pend = '0;
    do_reset();

    // ADDI, then SW under back-pressure with LW waiting
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    cyc(1'b1, 6'h01, 1'b0, 1'b1);
    cyc(1'b1, 6'h20, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 6'h1F, 1'b0, 1'b0);
    cyc(1'b1, 6'h1F, 1'b0, 1'b1);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);

    // DIV to completion, then DIV flushed two cycles after accept
    cyc(1'b1, 6'h06, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 6'h00, 1'b0, 1'b1);
    cyc(1'b1, 6'h06, 1'b0, 1'b1);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    cyc(1'b0, 6'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 6'h00, 1'b0, 1'b1);

    // undefined opcode then PRINT
    cyc(1'b1, 6'h2A, 1'b0, 1'b1);
    cyc(1'b1, 6'h21, 1'b0, 1'b1);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);

    // HALT stays put with fetch pushing, flush ignored, then reset recovers
    cyc(1'b1, 6'h3F, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 6'h00, (i == 5), 1'b1);
    do_reset();
    cyc(1'b1, 6'h0C, 1'b0, 1'b1);

    // asynchronous reset in the middle of a MUL
    cyc(1'b1, 6'h04, 1'b0, 1'b1);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    do_reset();
    cyc(1'b0, 6'h00, 1'b0, 1'b1);

    // randomized traffic
    halt_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      op = 6'($urandom_range(0, 33));
      else if (r < 85) op = 6'($urandom_range(4, 7));
      else if (r < 98) op = 6'($urandom_range(34, 62));
      else             op = 6'h3F;
      cyc($urandom_range(0, 3) != 0, op, $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0);
      halt_cycles = m_halt ? halt_cycles + 1 : 0;
      if (halt_cycles > 6 || $urandom_range(0, 299) == 0) begin
        do_reset();
        halt_cycles = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
